// File: rtl/fir_mac_stream_if.sv
// fir_mac_stream_if
//   Bundles the sample stream, the coefficient write bus and the result
//   stream of fir_mac_stream. clk and rst_n are not part of the bundle.
//
//   Signals:
//     in_valid    sample strobe; the sample is taken on every edge where it is high
//     in_data     sample value (DATA_WIDTH, unsigned)
//     coef_wr_en  shadow-bank write enable
//     coef_addr   tap index for the shadow write
//     coef_data   coefficient value (COEF_WIDTH, unsigned)
//     coef_commit copy the whole shadow bank into the active bank
//     out_valid   one-cycle result strobe
//     out_data    filtered result (OUT_WIDTH)
//     sat_flag    result was clipped (only when the FIR_SAT_EN macro is defined)
//
//   Modports: master = sample/coefficient source, slave = filter engine.

interface fir_mac_stream_if #(
  parameter int DATA_WIDTH = 4,
  parameter int COEF_WIDTH = 4,
  parameter int TAPS       = 4,
  parameter int OUT_WIDTH  = 10
);
  localparam int AW = $clog2(TAPS);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  coef_wr_en;
  logic [AW-1:0]         coef_addr;
  logic [COEF_WIDTH-1:0] coef_data;
  logic                  coef_commit;
  logic                  out_valid;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  sat_flag;

  modport master (
    output in_valid, in_data, coef_wr_en, coef_addr, coef_data, coef_commit,
    input  out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, coef_wr_en, coef_addr, coef_data, coef_commit,
    output out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/fir_mac_stream.sv
// fir_mac_stream
//   Streaming direct-form FIR: y = sum c[k] * x[n-k], unsigned operands.
//   The delay line shifts only on accepted samples, so idle cycles do not
//   age the data. Coefficients are written into a shadow bank and copied to
//   the active bank in a single edge by coef_commit. The multiply-accumulate
//   is a 2-stage registered pipeline: products one edge after acceptance,
//   sum one edge later, so out_valid rises after accept edge + 2.
//
//   Ports:
//     clk    clock, all state on the rising edge
//     rst_n  asynchronous active-low reset, clears every register
//     bus    fir_mac_stream_if.slave (sample stream, coefficient bus, result)
//
//   Optional feature (macro FIR_SAT_EN):
//     defined     - results above 2^OUT_WIDTH-1 clip to all ones, sat_flag=1
//     not defined - out_data is the low OUT_WIDTH bits of the sum, sat_flag=0

module fir_mac_stream #(
  parameter int DATA_WIDTH = 4,
  parameter int COEF_WIDTH = 4,
  parameter int TAPS       = 4,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS),
  parameter int OUT_WIDTH  = ACC_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  fir_mac_stream_if.slave bus
);
  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;

  // Per-tap views of the delay line and products, collected for the adder.
  logic [DATA_WIDTH-1:0] x_tap    [TAPS];
  logic [PW-1:0]         prod_tap [TAPS];

  // Valid pipe: v0 = sample in delay line, v1 = products ready, out = sum ready.
  logic                  v0_reg;
  logic                  v1_reg;
  logic                  out_valid_reg;
  logic [ACC_WIDTH-1:0]  sum_reg;
  logic [ACC_WIDTH-1:0]  sum_next;

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      // Each tap decodes its own address; indices >= TAPS match nothing.
      localparam logic [AW-1:0] TAP_ADDR = AW'(gi);

      logic [DATA_WIDTH-1:0] x_reg;
      logic [DATA_WIDTH-1:0] x_src;
      logic [COEF_WIDTH-1:0] shadow_reg;
      logic [COEF_WIDTH-1:0] active_reg;
      logic [PW-1:0]         prod_reg;

      if (gi == 0) begin : g_head
        assign x_src = bus.in_data;
      end else begin : g_body
        assign x_src = x_tap[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_reg      <= '0;
          shadow_reg <= '0;
          active_reg <= '0;
          prod_reg   <= '0;
        end else begin
          if (bus.in_valid) begin
            x_reg <= x_src;
          end
          if (bus.coef_wr_en && (bus.coef_addr == TAP_ADDR)) begin
            shadow_reg <= bus.coef_data;
          end
          // Commit samples the shadow value from before this edge, so a
          // write on the same edge lands in the shadow bank only.
          if (bus.coef_commit) begin
            active_reg <= shadow_reg;
          end
          // The product for a sample accepted at edge N is formed at N+1
          // with the active bank as it stands after edge N; a commit on the
          // accept edge therefore applies to that sample.
          if (v0_reg) begin
            prod_reg <= PW'(x_reg) * PW'(active_reg);
          end
        end
      end

      assign x_tap[gi]    = x_reg;
      assign prod_tap[gi] = prod_reg;
    end
  endgenerate

  // ACC_WIDTH carries $clog2(TAPS) guard bits, so this sum cannot overflow.
  always_comb begin
    sum_next = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_next = sum_next + ACC_WIDTH'(prod_tap[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_reg        <= 1'b0;
      v1_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
    end else begin
      v0_reg        <= bus.in_valid;
      v1_reg        <= v0_reg;
      out_valid_reg <= v1_reg;
      // The sum register only moves with a result, so out_data and sat_flag
      // hold their last value while out_valid is low.
      if (v1_reg) begin
        sum_reg <= sum_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;

`ifdef FIR_SAT_EN
  logic over_range;

  generate
    if (OUT_WIDTH < ACC_WIDTH) begin : g_sat
      assign over_range = |sum_reg[ACC_WIDTH-1:OUT_WIDTH];
    end else begin : g_nosat
      assign over_range = 1'b0;
    end
  endgenerate

  assign bus.out_data = over_range ? {OUT_WIDTH{1'b1}} : sum_reg[OUT_WIDTH-1:0];
  assign bus.sat_flag = over_range;
`else
  assign bus.out_data = sum_reg[OUT_WIDTH-1:0];
  assign bus.sat_flag = 1'b0;
`endif

endmodule

// File: doc/fir_mac_stream.md
Name: fir_mac_stream

Overview:
- Parametrised streaming sum-of-products (direct-form FIR) engine; successor to the fixed 4-tap sum_of_products datapath.
- Generalised tap count, separate coefficient width and output width.
- Delay line advances only on accepted samples (in_valid); coefficients held in a double-buffered register bank written over a simple bus.
- Sits between a sample source and downstream accumulator/result logic; 2-stage registered MAC pipeline.

Parameters:
- DATA_WIDTH, 4, sample width (unsigned)
- COEF_WIDTH, 4, coefficient width (unsigned)
- TAPS, 4, number of taps (>=2)
- ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+$clog2(TAPS), full-precision sum width (10 at defaults)
- OUT_WIDTH, ACC_WIDTH, output width (<= ACC_WIDTH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample strobe; sample accepted on every edge where high
- in_data  in  DATA_WIDTH  sample
- coef_wr_en  in  1  shadow-bank write enable
- coef_addr  in  $clog2(TAPS)  tap index for write
- coef_data  in  COEF_WIDTH  coefficient value
- coef_commit  in  1  copy shadow bank to active bank
- out_valid  out  1  one-cycle result strobe
- out_data  out  OUT_WIDTH  filtered result
- sat_flag  out  1  result clipped (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): delay line, shadow bank, active bank, product regs, sum reg, valid pipe, out_data, out_valid, sat_flag all 0.
- Delay line x[0..TAPS-1]: on accepting edge N, x[0]<=in_data, x[k]<=x[k-1]; no shift when in_valid low (bubbles do not age data).
- Stage 1 (edge N+1): p[k] <= x[k]*c_active[k], full DATA_WIDTH+COEF_WIDTH precision.
- Stage 2 (edge N+2): sum <= sum of p[k], ACC_WIDTH, unsigned, cannot overflow.
- out_valid high for exactly one cycle after edge N+2 per accepted sample; out_data holds last result when out_valid low.
- Back-to-back in_valid gives one out_valid per cycle; no stall, no backpressure.
- Result y = sum c[k]*x[n-k]; delay-line slots not yet filled since reset read as 0.
- coef_wr_en at edge M: shadow[coef_addr] <= coef_data; coef_addr >= TAPS ignored.
- coef_commit at edge M: active <= shadow (whole bank, one edge). Sample accepted at edge N uses new coefficients iff M <= N.
- coef_wr_en and coef_commit on same edge: commit copies pre-write shadow; write lands in shadow only.
- Reset mid-stream: pipeline results in flight are discarded, no out_valid after rst_n rises until a new sample passes through.
- OUT_WIDTH < ACC_WIDTH without macro: out_data = low OUT_WIDTH bits of sum (wrap); sat_flag 0.

Optional Feature:
- Macro FIR_SAT_EN.
- Defined: when sum > 2^OUT_WIDTH-1, out_data = all ones and sat_flag=1 alongside out_valid; otherwise sat_flag=0. sat_flag updates only with out_valid.
- Not defined: truncation as above; sat_flag tied 0.
- OUT_WIDTH == ACC_WIDTH: identical behaviour either way.

Test Plan:
- Impulse: write c={1,2,3,4}, commit, samples 1,0,0,0,0 back-to-back -> out_data 1,2,3,4,0, each out_valid 2 cycles after its accept edge.
- Full scale: c all 15, samples 15 x4 -> outputs 225,450,675,900 (0x384), no truncation at ACC_WIDTH=10.
- Bubbles: c={1,2,3,4}, samples 1 and 0 separated by 5 idle cycles -> second result 2 (not 0); exactly one out_valid per accepted sample.
- Commit timing: stream 1s with c={1,1,1,1}; write c={2,2,2,2}, commit on same edge as sample k -> sample k result 8 once line full, sample k-1 result 4; concurrent write+commit to addr 0 leaves active[0] old.
- Reset mid-stream: rst_n low for 1 cycle between samples with 2 results in flight -> no out_valid until next accept+2, all outputs 0 during reset, then results restart from zeroed delay line.
- OUT_WIDTH=8, c and samples all 15: with FIR_SAT_EN -> 4th output 255, sat_flag=1; without -> 132 (900 mod 256), sat_flag=0.
